draw_sequencer: RTL and testbench
=================================

// Module: draw_sequencer
// PURPOSE
//  Sequences and shares the single VGA plot port between the three drawing engines
//  (fillscreen, circle, reuleaux). Host commands are queued in a small FIFO and
//  launched one at a time over the engines' start/done handshake. Only the active
//  engine's pixels reach vga_adapter; off-screen pixels are clipped.
//  Sits between the top-level host logic and the engines plus vga_adapter.
// PARAMETERS
//  FIFO_DEPTH  4       command queue entries (power of 2, >=2)
//  SCREEN_W    160     plot clipped unless vga_x < SCREEN_W
//  SCREEN_H    120     plot clipped unless vga_y < SCREEN_H
//  TIMEOUT     65535   max cycles an engine may hold start without done before abort
// PORTS
//  clk          in   1     system clock, all logic on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  cmd_valid    in   1     host command present
//  cmd_ready    out  1     FIFO can accept (= !full)
//  cmd_shape    in   2     0=FILL 1=CIRCLE 2=REULEAUX 3=illegal
//  cmd_colour   in   3     shape colour
//  cmd_cx       in   8     centre x (ignored by FILL)
//  cmd_cy       in   7     centre y (ignored by FILL)
//  cmd_radius   in   8     radius (ignored by FILL)
//  eng_start    out  3     one-hot start, bit = shape code
//  eng_colour   out  3     latched colour, broadcast to all engines
//  eng_cx/cy/r  out  8/7/8 latched geometry, broadcast, stable while start high
//  eng_done     in   3     per-engine done
//  eng_x        in   24    {reu,cir,fill} x, 8b each
//  eng_y        in   21    {reu,cir,fill} y, 7b each
//  eng_vcolour  in   9     {reu,cir,fill} colour, 3b each
//  eng_plot     in   3     per-engine plot strobe
//  vga_x/y      out  8/7   to vga_adapter, registered
//  vga_colour   out  3     to vga_adapter, registered
//  vga_plot     out  1     to vga_adapter, registered
//  idle         out  1     FIFO empty and FSM in IDLE
//  err          out  1     sticky: illegal shape dropped or timeout; cleared by reset only
//  plot_count   out  16    pixels forwarded since reset, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: FIFO empty, FSM=IDLE, eng_start=0, vga_plot=0, vga_x/y/colour=0,
//   eng_colour/cx/cy/r=0, err=0, plot_count=0, idle=1, cmd_ready=1.
//  Push when cmd_valid&&cmd_ready. No bypass: when full, cmd_ready=0 even if a pop
//   occurs the same cycle. Push and pop in the same non-full cycle are both honoured.
//  FSM IDLE: FIFO non-empty -> pop and latch fields. Shape 3 -> set err, stay IDLE.
//   Legal shape -> LAUNCH; eng_start[shape]=1 on the next cycle.
//  LAUNCH: start held high, geometry held stable, timeout counter runs.
//   eng_done[shape]=1 -> RELEASE, start low on the next cycle.
//   Counter reaches TIMEOUT -> set err, go to RELEASE.
//  RELEASE: start=0. Wait for eng_done[shape]=0 (max TIMEOUT cycles, else set err),
//   then go to IDLE. A new command is never launched while the previous done is high.
//  Plot path: 1-cycle register. vga_plot(t+1) = eng_plot[act](t) && state==LAUNCH
//   && x<SCREEN_W && y<SCREEN_H. vga_x/y/colour follow the active engine every cycle.
//  Plots from inactive engines, and plots seen in RELEASE/IDLE, are discarded.
//  plot_count += 1 per forwarded pixel; saturates at 16'hFFFF.
//  Comparisons are unsigned, full port width. cx/cy/r pass through unmodified;
//   engines handle negative offsets, the sequencer only clips.
//  rst_n low mid-operation returns everything to reset values immediately
//   (async). Queued commands are lost.
// STRUCTURE
//  Package draw_pkg: typedef enum logic[1:0] shape_e {FILL,CIRCLE,REULEAUX,ILLEGAL};
//   struct draw_cmd_t {shape, colour, cx, cy, radius}; SCREEN_W/H defaults.
//  Sub-module cmd_fifo (synchronous FIFO of draw_cmd_t, FIFO_DEPTH, full/empty).
//  Top: FSM {IDLE, LAUNCH, RELEASE}, timeout counter, plot mux/clip register, counters.
// TESTING
//  1 FILL colour 0, then CIRCLE (80,60,r40,c3) -> eng_start 001 then 010; never
//    two bits set; each start rises 1 cycle after IDLE pop.
//  2 Push 5 cmds back-to-back with engines stalled -> cmd_ready low after 4;
//    all execute in order; idle=1 at end.
//  3 REULEAUX (159,60,r40) with model engine emitting x 120..200 -> vga_plot only for
//    x<160; plot_count equals in-bounds pixel count.
//  4 Inactive engine toggles plot during CIRCLE -> no vga_plot from it; shape 3 -> err=1,
//    no start, next cmd runs.
//  5 Engine never asserts done (TIMEOUT=100) -> start drops at cycle 101, err=1,
//    next cmd launches.
//  6 rst_n low during LAUNCH -> eng_start, vga_plot 0 that cycle; FIFO empty, idle=1.

Source files
------------

// File: rtl/draw_sequencer_pkg.sv
// Shared types for the draw sequencer: shape codes, the queued command record
// and default screen bounds.
package draw_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        CIRCLE   = 2'd1,
        REULEAUX = 2'd2,
        ILLEGAL  = 2'd3
    } shape_e;

    typedef struct packed {
        shape_e     shape;
        logic [2:0] colour;
        logic [7:0] cx;
        logic [6:0] cy;
        logic [7:0] radius;
    } draw_cmd_t;

    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;

    function automatic logic [2:0] shape_onehot(input shape_e s);
        return (s == ILLEGAL) ? 3'b000 : 3'(3'b001 << s);
    endfunction

endpackage

// File: rtl/draw_sequencer_cmd_fifo.sv
// Synchronous command FIFO. Full is derived from the occupancy count only, so a
// pop never frees a slot for a push in the same cycle.
module cmd_fifo
    import draw_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  logic      pop_i,
    input  draw_cmd_t wdata_i,
    output draw_cmd_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    draw_cmd_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     cnt_q;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Queues host draw commands, launches one engine at a time over start/done and
// forwards only the active engine's on-screen pixels to the VGA adapter.
//
// state   | meaning
// IDLE    | waiting for a queued command; pops and latches it
// LAUNCH  | start high to the selected engine, waiting for done or timeout
// RELEASE | start low, waiting for the engine to drop done
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H   = SCREEN_H_DEF,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_shape_i,
    input  logic [2:0]  cmd_colour_i,
    input  logic [7:0]  cmd_cx_i,
    input  logic [6:0]  cmd_cy_i,
    input  logic [7:0]  cmd_radius_i,
    output logic [2:0]  eng_start_o,
    output logic [2:0]  eng_colour_o,
    output logic [7:0]  eng_cx_o,
    output logic [6:0]  eng_cy_o,
    output logic [7:0]  eng_r_o,
    input  logic [2:0]  eng_done_i,
    input  logic [23:0] eng_x_i,
    input  logic [20:0] eng_y_i,
    input  logic [8:0]  eng_vcolour_i,
    input  logic [2:0]  eng_plot_i,
    output logic [7:0]  vga_x_o,
    output logic [6:0]  vga_y_o,
    output logic [2:0]  vga_colour_o,
    output logic        vga_plot_o,
    output logic        idle_o,
    output logic        err_o,
    output logic [15:0] plot_count_o
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_LAUNCH  = 2'd1;
    localparam logic [1:0]  ST_RELEASE = 2'd2;
    localparam logic [15:0] TMR_LOAD   = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    draw_cmd_t   cmd_q, cmd_d;
    logic        err_q, err_d;
    logic        pop;
    draw_cmd_t   fifo_wdata, fifo_rdata;
    logic        fifo_full, fifo_empty;

    logic        act_done, act_plot, plot_fwd;
    logic [7:0]  act_x;
    logic [6:0]  act_y;
    logic [2:0]  act_col;

    logic [7:0]  vga_x_q;
    logic [6:0]  vga_y_q;
    logic [2:0]  vga_col_q;
    logic        vga_plot_q;
    logic [15:0] plot_cnt_q;

    assign fifo_wdata = '{shape:  shape_e'(cmd_shape_i),
                          colour: cmd_colour_i,
                          cx:     cmd_cx_i,
                          cy:     cmd_cy_i,
                          radius: cmd_radius_i};

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid_i),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        act_done = 1'b0;
        act_plot = 1'b0;
        act_x    = '0;
        act_y    = '0;
        act_col  = '0;
        case (cmd_q.shape)
            FILL: begin
                act_done = eng_done_i[0];
                act_plot = eng_plot_i[0];
                act_x    = eng_x_i[7:0];
                act_y    = eng_y_i[6:0];
                act_col  = eng_vcolour_i[2:0];
            end
            CIRCLE: begin
                act_done = eng_done_i[1];
                act_plot = eng_plot_i[1];
                act_x    = eng_x_i[15:8];
                act_y    = eng_y_i[13:7];
                act_col  = eng_vcolour_i[5:3];
            end
            REULEAUX: begin
                act_done = eng_done_i[2];
                act_plot = eng_plot_i[2];
                act_x    = eng_x_i[23:16];
                act_y    = eng_y_i[20:14];
                act_col  = eng_vcolour_i[8:6];
            end
            default: ;
        endcase
    end

    // Timer is reloaded on every state entry and expires at zero, so start
    // stays high for exactly TIMEOUT cycles when done never arrives.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cmd_d   = cmd_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    cmd_d = fifo_rdata;
                    tmr_d = TMR_LOAD;
                    if (fifo_rdata.shape == ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                if (act_done) begin
                    state_d = ST_RELEASE;
                    tmr_d   = TMR_LOAD;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                    tmr_d   = TMR_LOAD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!act_done) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign plot_fwd = (state_q == ST_LAUNCH) && act_plot
                      && (32'(act_x) < SCREEN_W) && (32'(act_y) < SCREEN_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            cmd_q      <= '0;
            err_q      <= 1'b0;
            vga_x_q    <= '0;
            vga_y_q    <= '0;
            vga_col_q  <= '0;
            vga_plot_q <= 1'b0;
            plot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cmd_q      <= cmd_d;
            err_q      <= err_d;
            vga_x_q    <= act_x;
            vga_y_q    <= act_y;
            vga_col_q  <= act_col;
            vga_plot_q <= plot_fwd;
            if (plot_fwd && (plot_cnt_q != 16'hFFFF)) begin
                plot_cnt_q <= plot_cnt_q + 1'b1;
            end
        end
    end

    assign cmd_ready_o  = !fifo_full;
    assign eng_start_o  = (state_q == ST_LAUNCH) ? shape_onehot(cmd_q.shape) : 3'b000;
    assign eng_colour_o = cmd_q.colour;
    assign eng_cx_o     = cmd_q.cx;
    assign eng_cy_o     = cmd_q.cy;
    assign eng_r_o      = cmd_q.radius;
    assign vga_x_o      = vga_x_q;
    assign vga_y_o      = vga_y_q;
    assign vga_colour_o = vga_col_q;
    assign vga_plot_o   = vga_plot_q;
    assign idle_o       = fifo_empty && (state_q == ST_IDLE);
    assign err_o        = err_q;
    assign plot_count_o = plot_cnt_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: plot-path vector table plus hand-written
// sequences for queueing, clipping, illegal shapes, timeout and async reset.
module tb_draw_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_shape;
    logic [2:0]  cmd_colour;
    logic [7:0]  cmd_cx;
    logic [6:0]  cmd_cy;
    logic [7:0]  cmd_radius;
    logic [2:0]  eng_start;
    logic [2:0]  eng_colour;
    logic [7:0]  eng_cx;
    logic [6:0]  eng_cy;
    logic [7:0]  eng_r;
    logic [2:0]  eng_done;
    logic [23:0] eng_x;
    logic [20:0] eng_y;
    logic [8:0]  eng_vcolour;
    logic [2:0]  eng_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        idle;
    logic        err;
    logic [15:0] plot_count;

    int checks = 0;
    int errors = 0;
    int exp_pc = 0;

    always #5 clk = ~clk;

    draw_sequencer #(
        .FIFO_DEPTH (4),
        .SCREEN_W   (160),
        .SCREEN_H   (120),
        .TIMEOUT    (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_shape_i   (cmd_shape),
        .cmd_colour_i  (cmd_colour),
        .cmd_cx_i      (cmd_cx),
        .cmd_cy_i      (cmd_cy),
        .cmd_radius_i  (cmd_radius),
        .eng_start_o   (eng_start),
        .eng_colour_o  (eng_colour),
        .eng_cx_o      (eng_cx),
        .eng_cy_o      (eng_cy),
        .eng_r_o       (eng_r),
        .eng_done_i    (eng_done),
        .eng_x_i       (eng_x),
        .eng_y_i       (eng_y),
        .eng_vcolour_i (eng_vcolour),
        .eng_plot_i    (eng_plot),
        .vga_x_o       (vga_x),
        .vga_y_o       (vga_y),
        .vga_colour_o  (vga_colour),
        .vga_plot_o    (vga_plot),
        .idle_o        (idle),
        .err_o         (err),
        .plot_count_o  (plot_count)
    );

    typedef struct {
        logic [2:0] plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       exp_plot;
    } pvec_t;

    pvec_t tbl [12];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] sh, input logic [2:0] col,
                        input logic [7:0] cx, input logic [6:0] cy, input logic [7:0] r);
        cmd_valid  = 1'b1;
        cmd_shape  = sh;
        cmd_colour = col;
        cmd_cx     = cx;
        cmd_cy     = cy;
        cmd_radius = r;
        for (int i = 0; i < 50 && !cmd_ready; i++) tick;
        chk("push_ready", 32'(cmd_ready), 32'd1);
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string name, input logic [2:0] exp_start);
        for (int i = 0; i < 20 && eng_start == 3'b000; i++) tick;
        chk({name, "_start"}, 32'(eng_start), 32'(exp_start));
    endtask

    task automatic complete(input string name, input logic [2:0] exp_start, input logic [2:0] exp_col);
        wait_start(name, exp_start);
        chk({name, "_colour"}, 32'(eng_colour), 32'(exp_col));
        eng_done = exp_start;
        tick;
        chk({name, "_drop"}, 32'(eng_start), 32'd0);
        eng_done = 3'b000;
        tick;
    endtask

    // Never more than one engine started at once.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!$onehot0(eng_start)) begin
                errors++;
                $display("FAIL start_onehot actual=%b expected=at_most_one_bit", eng_start);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        logic exp_p;

        tbl[0]  = '{3'b010, 8'd10,  7'd10,  3'd1, 1'b1};
        tbl[1]  = '{3'b000, 8'd11,  7'd12,  3'd2, 1'b0};
        tbl[2]  = '{3'b001, 8'd12,  7'd13,  3'd3, 1'b0};
        tbl[3]  = '{3'b100, 8'd13,  7'd14,  3'd4, 1'b0};
        tbl[4]  = '{3'b010, 8'd159, 7'd119, 3'd5, 1'b1};
        tbl[5]  = '{3'b010, 8'd160, 7'd0,   3'd6, 1'b0};
        tbl[6]  = '{3'b010, 8'd0,   7'd120, 3'd7, 1'b0};
        tbl[7]  = '{3'b010, 8'd255, 7'd127, 3'd0, 1'b0};
        tbl[8]  = '{3'b111, 8'd80,  7'd60,  3'd3, 1'b1};
        tbl[9]  = '{3'b010, 8'd0,   7'd0,   3'd2, 1'b1};
        tbl[10] = '{3'b101, 8'd5,   7'd5,   3'd1, 1'b0};
        tbl[11] = '{3'b010, 8'd159, 7'd120, 3'd4, 1'b0};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_shape = '0; cmd_colour = '0;
        cmd_cx = '0; cmd_cy = '0; cmd_radius = '0;
        eng_done = '0; eng_x = '0; eng_y = '0; eng_vcolour = '0; eng_plot = '0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;

        chk("rst_start",  32'(eng_start),  32'd0);
        chk("rst_plot",   32'(vga_plot),   32'd0);
        chk("rst_vga_x",  32'(vga_x),      32'd0);
        chk("rst_idle",   32'(idle),       32'd1);
        chk("rst_ready",  32'(cmd_ready),  32'd1);
        chk("rst_err",    32'(err),        32'd0);
        chk("rst_pcount", 32'(plot_count), 32'd0);
        chk("rst_eng_cx", 32'(eng_cx),     32'd0);

        // FILL colour 0 then CIRCLE, with exact launch latency
        push(2'd0, 3'd0, 8'd0, 7'd0, 8'd0);
        chk("t1_fill_lag",   32'(eng_start), 32'd0);
        tick;
        chk("t1_fill_start", 32'(eng_start), 32'b001);
        chk("t1_fill_col",   32'(eng_colour), 32'd0);
        eng_done = 3'b001; tick;
        chk("t1_fill_drop",  32'(eng_start), 32'd0);
        eng_done = 3'b000; tick;

        push(2'd1, 3'd3, 8'd80, 7'd60, 8'd40);
        chk("t1_cir_lag",   32'(eng_start), 32'd0);
        tick;
        chk("t1_cir_start", 32'(eng_start), 32'b010);
        chk("t1_cir_cx",    32'(eng_cx),    32'd80);
        chk("t1_cir_cy",    32'(eng_cy),    32'd60);
        chk("t1_cir_r",     32'(eng_r),     32'd40);
        chk("t1_cir_col",   32'(eng_colour), 32'd3);

        for (int i = 0; i < 12; i++) begin
            eng_x       = {8'd200, tbl[i].x, 8'd30};
            eng_y       = {7'd100, tbl[i].y, 7'd5};
            eng_vcolour = {3'd7, tbl[i].col, 3'd6};
            eng_plot    = tbl[i].plot;
            tick;
            chk($sformatf("vec%0d_plot", i), 32'(vga_plot),   32'(tbl[i].exp_plot));
            chk($sformatf("vec%0d_x", i),    32'(vga_x),      32'(tbl[i].x));
            chk($sformatf("vec%0d_y", i),    32'(vga_y),      32'(tbl[i].y));
            chk($sformatf("vec%0d_col", i),  32'(vga_colour), 32'(tbl[i].col));
            if (tbl[i].exp_plot) exp_pc++;
        end
        eng_plot = 3'b000;
        eng_done = 3'b010; tick;
        chk("t1_cir_drop", 32'(eng_start), 32'd0);
        eng_plot = 3'b010;
        eng_x = {8'd0, 8'd10, 8'd0};
        eng_y = {7'd0, 7'd10, 7'd0};
        tick;
        chk("release_plot", 32'(vga_plot), 32'd0);
        chk("release_idle", 32'(idle),     32'd0);
        eng_plot = 3'b000;
        eng_done = 3'b000; tick;
        chk("t1_idle",   32'(idle),       32'd1);
        chk("t1_pcount", 32'(plot_count), 32'(exp_pc));

        // Five commands with stalled engines; FIFO fills, order preserved
        push(2'd0, 3'd1, 8'd1, 7'd1, 8'd1);
        push(2'd1, 3'd2, 8'd2, 7'd2, 8'd2);
        push(2'd2, 3'd3, 8'd3, 7'd3, 8'd3);
        push(2'd0, 3'd4, 8'd4, 7'd4, 8'd4);
        push(2'd1, 3'd5, 8'd5, 7'd5, 8'd5);
        chk("t2_full_ready", 32'(cmd_ready), 32'd0);
        chk("t2_q1_start",   32'(eng_start), 32'b001);
        chk("t2_q1_col",     32'(eng_colour), 32'd1);
        chk("t2_busy_idle",  32'(idle),      32'd0);
        eng_done = 3'b001; tick;
        chk("t2_q1_drop", 32'(eng_start), 32'd0);
        eng_done = 3'b000; tick;
        chk("t2_no_bypass", 32'(cmd_ready), 32'd0);
        tick;
        chk("t2_ready_after_pop", 32'(cmd_ready), 32'd1);
        complete("t2_q2", 3'b010, 3'd2);
        complete("t2_q3", 3'b100, 3'd3);
        complete("t2_q4", 3'b001, 3'd4);
        complete("t2_q5", 3'b010, 3'd5);
        chk("t2_idle", 32'(idle), 32'd1);

        // REULEAUX near the right edge; engine sweeps x across the clip boundary
        push(2'd2, 3'd4, 8'd159, 7'd60, 8'd40);
        wait_start("t3", 3'b100);
        chk("t3_cx", 32'(eng_cx), 32'd159);
        chk("t3_cy", 32'(eng_cy), 32'd60);
        chk("t3_r",  32'(eng_r),  32'd40);
        for (int x = 120; x <= 200; x++) begin
            eng_x       = {8'(x), 16'd0};
            eng_y       = {7'd60, 14'd0};
            eng_vcolour = {3'd4, 6'd0};
            eng_plot    = 3'b100;
            tick;
            exp_p = (x < 160);
            chk($sformatf("t3_x%0d_plot", x), 32'(vga_plot), 32'(exp_p));
            if (exp_p) exp_pc++;
        end
        eng_plot = 3'b000;
        chk("t3_pcount", 32'(plot_count), 32'(exp_pc));
        complete("t3", 3'b100, 3'd4);

        // Inactive engines plotting during CIRCLE, then an illegal shape
        push(2'd1, 3'd6, 8'd20, 7'd20, 8'd5);
        wait_start("t4", 3'b010);
        eng_x = {8'd10, 8'd10, 8'd10};
        eng_y = {7'd10, 7'd10, 7'd10};
        for (int i = 0; i < 6; i++) begin
            eng_plot = (i % 2 == 0) ? 3'b101 : 3'b000;
            tick;
            chk($sformatf("t4_inactive%0d", i), 32'(vga_plot), 32'd0);
        end
        eng_plot = 3'b000;
        complete("t4", 3'b010, 3'd6);
        chk("t4_err_clear", 32'(err), 32'd0);
        push(2'd3, 3'd7, 8'd1, 7'd1, 8'd1);
        push(2'd0, 3'd5, 8'd0, 7'd0, 8'd0);
        chk("t4_illegal_err",   32'(err),       32'd1);
        chk("t4_illegal_start", 32'(eng_start), 32'd0);
        complete("t4_after_ill", 3'b001, 3'd5);
        chk("t4_pcount", 32'(plot_count), 32'(exp_pc));

        // Async reset while LAUNCH with queued commands and an active plot
        push(2'd1, 3'd3, 8'd80, 7'd60, 8'd40);
        push(2'd0, 3'd1, 8'd0, 7'd0, 8'd0);
        push(2'd2, 3'd2, 8'd0, 7'd0, 8'd0);
        chk("t6_launch", 32'(eng_start), 32'b010);
        eng_x = {8'd0, 8'd10, 8'd0};
        eng_y = {7'd0, 7'd10, 7'd0};
        eng_plot = 3'b010;
        tick;
        chk("t6_pre_plot", 32'(vga_plot), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_start",  32'(eng_start),  32'd0);
        chk("t6_plot",   32'(vga_plot),   32'd0);
        chk("t6_idle",   32'(idle),       32'd1);
        chk("t6_ready",  32'(cmd_ready),  32'd1);
        chk("t6_err",    32'(err),        32'd0);
        chk("t6_pcount", 32'(plot_count), 32'd0);
        chk("t6_cx",     32'(eng_cx),     32'd0);
        eng_plot = 3'b000;
        tick;
        rst_n = 1'b1;
        exp_pc = 0;
        repeat (3) tick;
        chk("t6_lost_start", 32'(eng_start), 32'd0);
        chk("t6_lost_idle",  32'(idle),      32'd1);

        // Engine never answers: abort after TIMEOUT cycles, next command runs
        push(2'd0, 3'd2, 8'd0, 7'd0, 8'd0);
        push(2'd1, 3'd6, 8'd50, 7'd50, 8'd10);
        wait_start("t5", 3'b001);
        hi = 1;
        while (hi < 300) begin
            tick;
            if (eng_start == 3'b000) break;
            hi++;
        end
        chk("t5_start_cycles", 32'(hi),  32'd100);
        chk("t5_err",          32'(err), 32'd1);
        complete("t5_next", 3'b010, 3'd6);
        chk("t5_idle",   32'(idle),       32'd1);
        chk("t5_pcount", 32'(plot_count), 32'(exp_pc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
